// File: rtl/count_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// count_uart_tx : sends every new 4-bit counter value as one ASCII hex char
//                 over an 8N1 UART line.                        Revision 1.0
// ============================================================================
module count_uart_tx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] Q,
  output logic       Tx,
  output logic       Busy,
  output logic       Overrun
);
  localparam int DIVISOR = CLK_HZ / BAUD;
  localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  generate
    if (DIVISOR < 2) begin : g_divisor_check
      $error("count_uart_tx: CLK_HZ / BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_sent;
  logic [3:0]       r_q_prev;
  logic             r_valid;
  logic             r_chg;
  logic [7:0]       r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic             r_tx;
  logic             r_busy;
  logic             r_overrun;
  logic             w_tx_nxt;
  logic             w_trigger;
  logic             w_bit_end;
  logic             w_in_frame;
  logic             w_q_changed;
  logic             w_q_is_sent;
  logic             w_overrun;
  logic [7:0]       w_char;

  assign w_trigger   = !r_valid || (Q != r_sent);
  assign w_bit_end   = (r_cnt == C_CNT_LAST);
  assign w_in_frame  = (r_state != S_IDLE);
  assign w_q_changed = (Q != r_q_prev);
  assign w_q_is_sent = (Q == r_sent);
  // A return to the value already on the line owes nothing, so never flags.
  assign w_overrun   = w_in_frame && w_q_changed && !w_q_is_sent && r_chg;
  assign w_char      = (Q < 4'd10) ? (8'h30 + {4'd0, Q}) : (8'h37 + {4'd0, Q});

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) w_state_nxt = S_START;
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line outputs are registered one cycle behind the state, glitch-free.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sent    <= 4'd0;
      r_q_prev  <= 4'd0;
      r_valid   <= 1'b0;
      r_chg     <= 1'b0;
      r_shift   <= 8'd0;
      r_cnt     <= '0;
      r_bit     <= 3'd0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_q_prev  <= Q;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_in_frame;
      r_overrun <= w_overrun;
      if (!w_in_frame || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
      if (w_in_frame && w_q_changed) begin
        r_chg <= !w_q_is_sent;
      end
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_shift <= w_char;
            r_sent  <= Q;
            r_valid <= 1'b1;
            r_chg   <= 1'b0;
            r_bit   <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Tx      = r_tx;
  assign Busy    = r_busy;
  assign Overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_count_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_count_uart_tx : randomized scoreboard bench for count_uart_tx.
//                    Revision 1.0
// ============================================================================
module tb_count_uart_tx;
  localparam int CLK_HZ = 40;
  localparam int BAUD   = 10;
  localparam int D      = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * D;

  logic       Clock   = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] Q       = 4'd0;
  logic       Tx;
  logic       Busy;
  logic       Overrun;

  count_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Q       (Q),
    .Tx      (Tx),
    .Busy    (Busy),
    .Overrun (Overrun)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: edge-numbered view of which characters go out when.
  typedef struct { int ch; int st; } frame_t;
  frame_t exp_q[$];
  int     ovr_q[$];
  string  hex = "0123456789ABCDEF";
  int     cyc = 0;
  bit     m_valid = 0, m_owed = 0, m_have = 0;
  int     m_sent = 0, m_qprev = 0, m_start = 0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_valid = 0; m_owed = 0; m_have = 0;
      m_sent = 0; m_qprev = 0; m_start = 0;
      exp_q.delete();
      ovr_q.delete();
    end else begin
      cyc++;
      if (m_have && cyc > m_start && cyc <= m_start + FRAME) begin
        if (int'(Q) != m_qprev) begin
          if (int'(Q) == m_sent) m_owed = 0;
          else if (m_owed)       ovr_q.push_back(cyc);
          else                   m_owed = 1;
        end
      end else if (!m_valid || int'(Q) != m_sent) begin
        exp_q.push_back('{ch: int'(hex.getc(int'(Q))), st: cyc});
        m_sent = int'(Q); m_valid = 1; m_owed = 0; m_have = 1; m_start = cyc;
      end
      m_qprev = int'(Q);
    end
  end

  // Monitor: decodes the serial line and checks against the queues.
  bit   mon_act = 0, mon_post = 0, have_prev = 0, busy_all = 0;
  int   mon_idx = 0, mon_first = 0, prev_first = 0;
  bit   smp [FRAME];

  task automatic finish_frame();
    bit         stable;
    logic [7:0] b;
    frame_t     e;
    stable = 1;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < D; j++)
        if (smp[k*D+j] != smp[k*D]) stable = 0;
    chk("bit_width_stable", int'(stable), 1);
    chk("start_bit", int'(smp[0]), 0);
    chk("stop_bit", int'(smp[9*D]), 1);
    for (int k = 0; k < 8; k++) b[k] = smp[(k+1)*D];
    chk("busy_during_frame", int'(busy_all), 1);
    if (have_prev) chk("start_spacing_ok", int'(mon_first - prev_first >= FRAME + 1), 1);
    have_prev  = 1;
    prev_first = mon_first;
    chk("frame_expected", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("frame_char", int'(b), e.ch);
      chk("frame_start_edge", mon_first - 1, e.st);
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset_n) begin
      mon_act = 0; mon_post = 0; have_prev = 0;
      chk("reset_tx", int'(Tx), 1);
      chk("reset_busy", int'(Busy), 0);
      chk("reset_overrun", int'(Overrun), 0);
    end else begin
      if (ovr_q.size() > 0 && ovr_q[0] == cyc) begin
        chk("overrun_pulse", int'(Overrun), 1);
        void'(ovr_q.pop_front());
      end else begin
        chk("overrun_quiet", int'(Overrun), 0);
      end
      if (mon_post) begin
        chk("busy_after_frame", int'(Busy), 0);
        mon_post = 0;
      end
      if (!mon_act && Tx == 1'b0) begin
        mon_act = 1; mon_idx = 0; mon_first = cyc; busy_all = 1;
      end
      if (mon_act) begin
        smp[mon_idx] = Tx;
        busy_all     = busy_all & Busy;
        mon_idx++;
        if (mon_idx == FRAME) begin
          finish_frame();
          mon_act  = 0;
          mon_post = 1;
        end
      end
    end
  end

  initial begin
    int w;
    repeat (4) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (60) @(negedge Clock);
    Q = 4'd10;
    repeat (55) @(negedge Clock);
    Q = 4'd1;
    repeat (5) @(negedge Clock);
    Q = 4'd2;
    repeat (6) @(negedge Clock);
    Q = 4'd3;
    repeat (100) @(negedge Clock);
    Q = 4'd1;
    repeat (5) @(negedge Clock);
    Q = 4'd2;
    repeat (6) @(negedge Clock);
    Q = 4'd1;
    repeat (60) @(negedge Clock);
    Q = 4'd15;
    repeat (10) @(negedge Clock);
    Q = 4'd0;
    repeat (100) @(negedge Clock);
    repeat (600) begin
      @(negedge Clock);
      if ($urandom_range(0, 5) == 0) Q = 4'($urandom_range(0, 15));
    end
    Q = 4'd2;
    repeat (100) @(negedge Clock);
    // '7' = 0x37: data bit 3 is 0, so the line is low right before reset.
    Q = 4'd7;
    w = 0;
    while (!Busy && w < 50) begin
      @(negedge Clock);
      w++;
    end
    chk("busy_seen", int'(Busy), 1);
    repeat (17) @(negedge Clock);
    chk("tx_data_bit3", int'(Tx), 0);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_reset_tx", int'(Tx), 1);
    chk("async_reset_busy", int'(Busy), 0);
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (60) @(negedge Clock);
    chk("frames_outstanding", int'(exp_q.size()), 0);
    chk("overruns_outstanding", int'(ovr_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
